// File: rtl/dct_row_loader.sv
// dct_row_loader: gathers eight serial 8-bit pixels into one parallel row a..h for the DCT butterflies.
// Latency: the row is presented (row_valid, a..h) in the cycle after the 8th-pixel accept; one row per 8 cycles sustained.
// Backpressure: pix_ready drops only when the 8th pixel is offered while a presented row is not being consumed.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   pix_in/pix_valid/pix_ready   serial pixel input handshake
//   a..h                  row samples 0..7 in arrival order (registered)
//   row_valid/row_ready   row output handshake
//   row_idx               index 0..7 of the presented row within its 8x8 block
//   block_last            presented row is the last row of its block
// Build option: define DCT_LEVEL_SHIFT_EN to store pixels level-shifted (pix_in ^ 8'h80, signed -128..127).

module dct_row_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] d,
  output logic [7:0] e,
  output logic [7:0] f,
  output logic [7:0] g,
  output logic [7:0] h,
  output logic       row_valid,
  input  logic       row_ready,
  output logic [2:0] row_idx,
  output logic       block_last
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [7:0] stage [0:6];
  logic [7:0] pix_store;
  logic       accept;
  logic       last_accept;
  logic       handoff;

`ifdef DCT_LEVEL_SHIFT_EN
  // Flipping the MSB is the same as subtracting 128 and reading the byte as two's complement.
  assign pix_store = pix_in ^ 8'h80;
`else
  assign pix_store = pix_in;
`endif

  assign row_valid   = (state == S_FULL);
  assign handoff     = row_valid && row_ready;
  // Pixels 0..6 always have a staging slot; only the row-completing pixel needs the output register free.
  assign pix_ready   = !((cnt == 3'd7) && row_valid && !row_ready);
  assign accept      = pix_valid && pix_ready;
  assign last_accept = accept && (cnt == 3'd7);
  assign block_last  = row_valid && (row_idx == 3'd7);

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (last_accept) state_nxt = S_FULL;
      // A handoff coinciding with a new row completion keeps the register full with the new row.
      S_FULL:  if (handoff && !last_accept) state_nxt = S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_EMPTY;
      cnt     <= 3'd0;
      row_idx <= 3'd0;
      for (int i = 0; i < 7; i++) stage[i] <= 8'h00;
      a <= 8'h00;
      b <= 8'h00;
      c <= 8'h00;
      d <= 8'h00;
      e <= 8'h00;
      f <= 8'h00;
      g <= 8'h00;
      h <= 8'h00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= cnt + 3'd1;
      end
      for (int i = 0; i < 7; i++) begin
        if (accept && (cnt == 3'(i))) stage[i] <= pix_store;
      end
      // The 8th pixel bypasses staging and goes straight to h.
      if (last_accept) begin
        a <= stage[0];
        b <= stage[1];
        c <= stage[2];
        d <= stage[3];
        e <= stage[4];
        f <= stage[5];
        g <= stage[6];
        h <= pix_store;
      end
      if (handoff) begin
        row_idx <= row_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_dct_row_loader.sv
// Directed bench for dct_row_loader: reset, basic row, backpressure, full block, sparse input, mid-row reset.
// Inputs change 2 time units after each rising edge; outputs are sampled there too.
// Expected rows are built from the pixel values written in each test.

module tb_dct_row_loader;

  logic       clk;
  logic       rst_n;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] a, b, c, d, e, f, g, h;
  logic       row_valid;
  logic       row_ready;
  logic [2:0] row_idx;
  logic       block_last;

  int checks;
  int failures;

  dct_row_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .e          (e),
    .f          (f),
    .g          (g),
    .h          (h),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_idx    (row_idx),
    .block_last (block_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xf(input logic [7:0] p);
`ifdef DCT_LEVEL_SHIFT_EN
    return p ^ 8'h80;
`else
    return p;
`endif
  endfunction

  // Expected {a..h} for eight consecutive pixel values starting at base.
  function automatic logic [63:0] row_of(input logic [7:0] base);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[55:0], xf(base + 8'(i))};
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_in    = 8'h00;
    row_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (row_valid !== 1'b0) begin failures++; $display("FAIL reset_row_valid got=%b exp=0", row_valid); end
    checks++;
    if (pix_ready !== 1'b1) begin failures++; $display("FAIL reset_pix_ready got=%b exp=1", pix_ready); end
    checks++;
    if (block_last !== 1'b0) begin failures++; $display("FAIL reset_block_last got=%b exp=0", block_last); end
    checks++;
    if (row_idx !== 3'd0) begin failures++; $display("FAIL reset_row_idx got=%0d exp=0", row_idx); end
    checks++;
    if ({a, b, c, d, e, f, g, h} !== 64'h0) begin
      failures++; $display("FAIL reset_bytes got=%h exp=0", {a, b, c, d, e, f, g, h});
    end
  endtask

  task automatic test_basic_row();
    do_reset();
    row_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pix_valid = 1'b1;
      pix_in    = 8'h10 + 8'(i);
      cyc();
      if (i == 6) begin
        checks++;
        if (row_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", row_valid); end
      end
    end
    pix_valid = 1'b0;
    checks++;
    if (row_valid !== 1'b1) begin failures++; $display("FAIL basic_row_valid got=%b exp=1", row_valid); end
    checks++;
    if ({a, b, c, d, e, f, g, h} !== row_of(8'h10)) begin
      failures++; $display("FAIL basic_bytes got=%h exp=%h", {a, b, c, d, e, f, g, h}, row_of(8'h10));
    end
    checks++;
    if (row_idx !== 3'd0) begin failures++; $display("FAIL basic_row_idx got=%0d exp=0", row_idx); end
    cyc();
    checks++;
    if (row_valid !== 1'b0 || row_idx !== 3'd1) begin
      failures++; $display("FAIL basic_after_handoff got=%b/%0d exp=0/1", row_valid, row_idx);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    row_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      pix_valid = 1'b1;
      pix_in    = 8'h20 + 8'(i);
      #1;
      checks++;
      if (pix_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_pix%0d got=%b exp=1", i, pix_ready); end
      cyc();
    end
    checks++;
    if (row_valid !== 1'b1 || {a, b, c, d, e, f, g, h} !== row_of(8'h20)) begin
      failures++; $display("FAIL bp_row1 got=%b/%h exp=1/%h", row_valid, {a, b, c, d, e, f, g, h}, row_of(8'h20));
    end
    pix_in = 8'h2F;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (pix_ready !== 1'b0) begin failures++; $display("FAIL bp_stall%0d got=%b exp=0", k, pix_ready); end
      cyc();
      checks++;
      if ({a, b, c, d, e, f, g, h} !== row_of(8'h20)) begin
        failures++; $display("FAIL bp_hold%0d got=%h exp=%h", k, {a, b, c, d, e, f, g, h}, row_of(8'h20));
      end
    end
    row_ready = 1'b1;
    #1;
    checks++;
    if (pix_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", pix_ready); end
    cyc();
    row_ready = 1'b0;
    pix_valid = 1'b0;
    checks++;
    if (row_valid !== 1'b1) begin failures++; $display("FAIL bp_row2_valid got=%b exp=1", row_valid); end
    checks++;
    if ({a, b, c, d, e, f, g, h} !== row_of(8'h28)) begin
      failures++; $display("FAIL bp_row2_bytes got=%h exp=%h", {a, b, c, d, e, f, g, h}, row_of(8'h28));
    end
    checks++;
    if (row_idx !== 3'd1) begin failures++; $display("FAIL bp_row2_idx got=%0d exp=1", row_idx); end
  endtask

  task automatic test_block();
    do_reset();
    row_ready = 1'b1;
    for (int k = 0; k < 72; k++) begin
      pix_valid = 1'b1;
      pix_in    = 8'(k);
      #1;
      checks++;
      if (pix_ready !== 1'b1) begin failures++; $display("FAIL blk_ready_pix%0d got=%b exp=1", k, pix_ready); end
      cyc();
      if (k % 8 == 7) begin
        checks++;
        if (row_valid !== 1'b1 || row_idx !== 3'((k / 8) % 8)) begin
          failures++; $display("FAIL blk_row%0d_valid_idx got=%b/%0d exp=1/%0d", k / 8, row_valid, row_idx, (k / 8) % 8);
        end
        checks++;
        if (block_last !== (((k / 8) % 8) == 7)) begin
          failures++; $display("FAIL blk_row%0d_last got=%b exp=%b", k / 8, block_last, (((k / 8) % 8) == 7));
        end
        checks++;
        if ({a, b, c, d, e, f, g, h} !== row_of(8'(k - 7))) begin
          failures++; $display("FAIL blk_row%0d_bytes got=%h exp=%h", k / 8, {a, b, c, d, e, f, g, h}, row_of(8'(k - 7)));
        end
      end else begin
        checks++;
        if (row_valid !== 1'b0 || block_last !== 1'b0) begin
          failures++; $display("FAIL blk_gap_pix%0d got=%b/%b exp=0/0", k, row_valid, block_last);
        end
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_sparse();
    do_reset();
    row_ready = 1'b0;
    for (int t = 0; t < 15; t++) begin
      pix_valid = (t % 2 == 0);
      pix_in    = (t % 2 == 0) ? 8'h40 + 8'(t / 2) : 8'hEE;
      #1;
      checks++;
      if (pix_ready !== 1'b1) begin failures++; $display("FAIL sparse_ready_t%0d got=%b exp=1", t, pix_ready); end
      if (t == 14) begin
        checks++;
        if (row_valid !== 1'b0) begin failures++; $display("FAIL sparse_early_valid got=%b exp=0", row_valid); end
      end
      cyc();
    end
    pix_valid = 1'b0;
    checks++;
    if (row_valid !== 1'b1 || {a, b, c, d, e, f, g, h} !== row_of(8'h40)) begin
      failures++; $display("FAIL sparse_row got=%b/%h exp=1/%h", row_valid, {a, b, c, d, e, f, g, h}, row_of(8'h40));
    end
  endtask

  task automatic test_reset_mid_row();
    do_reset();
    row_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1;
      pix_in    = 8'h55 + 8'(i);
      cyc();
    end
    pix_valid = 1'b0;
    rst_n     = 1'b0;
    cyc();
    checks++;
    if (row_valid !== 1'b0 || pix_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_state got=%b/%b exp=0/1", row_valid, pix_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pix_valid = 1'b1;
      pix_in    = 8'hA0 + 8'(i);
      cyc();
    end
    pix_valid = 1'b0;
    checks++;
    if (row_valid !== 1'b1 || {a, b, c, d, e, f, g, h} !== row_of(8'hA0)) begin
      failures++; $display("FAIL midrst_row got=%b/%h exp=1/%h", row_valid, {a, b, c, d, e, f, g, h}, row_of(8'hA0));
    end
    checks++;
    if (row_idx !== 3'd0) begin failures++; $display("FAIL midrst_row_idx got=%0d exp=0", row_idx); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    pix_in    = 8'h00;
    pix_valid = 1'b0;
    row_ready = 1'b0;
    test_reset();
    test_basic_row();
    test_backpressure();
    test_block();
    test_sparse();
    test_reset_mid_row();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
